// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: each channel produces a 50%-duty slow clock
// and a toggle strobe; new half-periods are staged and only take effect at a period boundary.
module clk_div_multi #(
   parameter int N_CH         = 4,
   parameter int CNT_W        = 27,
   parameter int DEFAULT_HALF = 2500000,
   parameter int CH_W         = 2
) (
   input  logic             speed_clock,
   input  logic             reset,
   input  logic [N_CH-1:0]  enable,
   input  logic             div_load,
   input  logic [CH_W-1:0]  div_ch,
   input  logic [CNT_W-1:0] div_value,
   output logic [N_CH-1:0]  low_clock,
   output logic [N_CH-1:0]  tick,
   output logic [N_CH-1:0]  div_pending
);

   localparam logic [CNT_W-1:0] DEF_HALF = CNT_W'(DEFAULT_HALF);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [CNT_W-1:0] active_q, active_d;
      logic [CNT_W-1:0] pending_q, pending_d;
      logic [CNT_W-1:0] half_eff;
      logic             pend_q, pend_d;
      logic             low_q, low_d;
      logic             tick_q, tick_d;
      logic             load_hit;
      logic             wrap;

      // A programmed half-period of zero behaves as one cycle.
      assign half_eff = (active_q == '0) ? ONE : active_q;
      assign load_hit = div_load && (div_ch == CH_W'(g));
      assign wrap     = enable[g] && (cnt_q == half_eff - ONE);

      always_comb begin
         cnt_d     = cnt_q;
         active_d  = active_q;
         pending_d = pending_q;
         pend_d    = pend_q;
         low_d     = low_q;
         tick_d    = 1'b0;
         if (enable[g]) begin
            if (wrap) begin
               cnt_d  = '0;
               low_d  = ~low_q;
               tick_d = 1'b1;
            end else begin
               cnt_d  = cnt_q + ONE;
            end
         end else begin
            cnt_d = '0;
            low_d = 1'b0;
         end
         // The staged value is consumed at a wrap or on any idle cycle; a load in the
         // same cycle lands after that, so it waits for the next boundary.
         if (pend_q && (wrap || !enable[g])) begin
            active_d = pending_q;
            pend_d   = 1'b0;
         end
         if (load_hit) begin
            pending_d = div_value;
            pend_d    = 1'b1;
         end
      end

      always_ff @(posedge speed_clock or negedge reset) begin
         if (!reset) begin
            cnt_q     <= '0;
            active_q  <= DEF_HALF;
            pending_q <= DEF_HALF;
            pend_q    <= 1'b0;
            low_q     <= 1'b0;
            tick_q    <= 1'b0;
         end else begin
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            pend_q    <= pend_d;
            low_q     <= low_d;
            tick_q    <= tick_d;
         end
      end

      assign low_clock[g]   = low_q;
      assign tick[g]        = tick_q;
      assign div_pending[g] = pend_q;
   end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: scenario tasks with directed period checks plus a
// countdown-based reference model compared every cycle.
module tb_clk_div_multi;
  localparam int N_CH  = 2;
  localparam int CNT_W = 8;
  localparam int DEF   = 3;
  localparam int CH_W  = 2;
  localparam int VW    = 3 * N_CH;

  logic             speed_clock = 1'b0;
  logic             reset       = 1'b0;
  logic [N_CH-1:0]  enable      = '0;
  logic             div_load    = 1'b0;
  logic [CH_W-1:0]  div_ch      = '0;
  logic [CNT_W-1:0] div_value   = '0;
  logic [N_CH-1:0]  low_clock;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  div_pending;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: cycles remaining until the next toggle, plus a staged value.
  int m_act [N_CH];
  int m_pv  [N_CH];
  int m_rem [N_CH];
  bit m_pf  [N_CH];
  bit m_low [N_CH];
  bit m_tick[N_CH];

  clk_div_multi #(
    .N_CH(N_CH), .CNT_W(CNT_W), .DEFAULT_HALF(DEF), .CH_W(CH_W)
  ) dut (
    .speed_clock(speed_clock),
    .reset(reset),
    .enable(enable),
    .div_load(div_load),
    .div_ch(div_ch),
    .div_value(div_value),
    .low_clock(low_clock),
    .tick(tick),
    .div_pending(div_pending)
  );

  always #5 speed_clock = ~speed_clock;

  function automatic int hmax(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_act[c] = DEF; m_pv[c] = DEF; m_pf[c] = 1'b0;
      m_rem[c] = hmax(DEF); m_low[c] = 1'b0; m_tick[c] = 1'b0;
    end
  endfunction

  function automatic void model_step();
    for (int c = 0; c < N_CH; c++) begin
      if (enable[c]) begin
        m_rem[c] = m_rem[c] - 1;
        m_tick[c] = 1'b0;
        if (m_rem[c] == 0) begin
          m_low[c]  = !m_low[c];
          m_tick[c] = 1'b1;
          if (m_pf[c]) begin m_act[c] = m_pv[c]; m_pf[c] = 1'b0; end
          m_rem[c] = hmax(m_act[c]);
        end
      end else begin
        m_low[c] = 1'b0; m_tick[c] = 1'b0;
        if (m_pf[c]) begin m_act[c] = m_pv[c]; m_pf[c] = 1'b0; end
        m_rem[c] = hmax(m_act[c]);
      end
      if (div_load && int'(div_ch) == c) begin
        m_pv[c] = int'(div_value); m_pf[c] = 1'b1;
      end
    end
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [N_CH-1:0] l, t, p;
    for (int c = 0; c < N_CH; c++) begin
      l[c] = m_low[c]; t[c] = m_tick[c]; p[c] = m_pf[c];
    end
    return {l, t, p};
  endfunction

  task automatic clk_step();
    @(posedge speed_clock);
    if (reset) model_step();
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    reset = 1'b0;
    #12;
    n_cmp++;
    if ({low_clock, tick, div_pending} !== '0) begin
      n_err++; $display("FAIL reset_state got %b exp %b", {low_clock, tick, div_pending}, {VW{1'b0}});
    end
    enable = 2'b11;
    reset  = 1'b1;
  endtask

  task automatic test_default_period(input string name);
    logic [N_CH-1:0] el, et;
    for (int k = 1; k <= 14; k++) begin
      clk_step();
      el = ((k / 3) % 2 == 1) ? 2'b11 : 2'b00;
      et = (k % 3 == 0) ? 2'b11 : 2'b00;
      n_cmp++;
      if ({low_clock, tick} !== {el, et}) begin
        n_err++; $display("FAIL %s k %0d got low/tick %b exp %b", name, k, {low_clock, tick}, {el, et});
      end
      n_cmp++;
      if ({low_clock, tick, div_pending} !== exp_vec()) begin
        n_err++; $display("FAIL %s_model cyc %0d got %b exp %b", name, cyc, {low_clock, tick, div_pending}, exp_vec());
      end
    end
  endtask

  task automatic test_load_midperiod();
    int since;
    int gaps[$];
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      clk_step();
      if (tick[0] === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin n_err++; $display("FAIL midload_sync got no tick exp tick within 10"); end
    div_ch = 0; div_value = 5; div_load = 1'b1;
    since = 0;
    for (int i = 0; i < 16; i++) begin
      clk_step();
      div_load = 1'b0;
      since++;
      if (i == 0) begin
        n_cmp++;
        if (div_pending !== 2'b01) begin n_err++; $display("FAIL midload_pending got %b exp 01", div_pending); end
      end
      n_cmp++;
      if ({low_clock, tick, div_pending} !== exp_vec()) begin
        n_err++; $display("FAIL midload cyc %0d got %b exp %b", cyc, {low_clock, tick, div_pending}, exp_vec());
      end
      if (tick[0] === 1'b1) begin gaps.push_back(since); since = 0; end
    end
    n_cmp++;
    if (gaps.size() < 3 || gaps[0] != 3 || gaps[1] != 5 || gaps[2] != 5) begin
      n_err++; $display("FAIL midload_gaps got %p exp 3,5,5", gaps);
    end
  endtask

  task automatic test_load_zero();
    div_ch = 1; div_value = 0; div_load = 1'b1;
    for (int i = 0; i < 12; i++) begin
      clk_step();
      div_load = 1'b0;
      n_cmp++;
      if ({low_clock, tick, div_pending} !== exp_vec()) begin
        n_err++; $display("FAIL load_zero cyc %0d got %b exp %b", cyc, {low_clock, tick, div_pending}, exp_vec());
      end
      if (i >= 8) begin
        n_cmp++;
        if (tick[1] !== 1'b1) begin n_err++; $display("FAIL load_zero_tick i %0d got %b exp 1", i, tick[1]); end
      end
    end
  endtask

  task automatic test_load_on_wrap();
    int since;
    int gaps[$];
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      clk_step();
      if (tick[0] === 1'b1) seen = 1'b1;
    end
    div_ch = 0; div_value = 4; div_load = 1'b1;
    clk_step();
    div_load = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      if (m_rem[0] == 1) seen = 1'b1;
      else clk_step();
    end
    n_cmp++;
    if (!seen || div_pending[0] !== 1'b1) begin
      n_err++; $display("FAIL wrap_setup got seen %0d pend %b exp 1 1", seen, div_pending[0]);
    end
    div_value = 7; div_load = 1'b1;
    clk_step();
    div_load = 1'b0;
    n_cmp++;
    if ({tick[0], div_pending[0]} !== 2'b11) begin
      n_err++; $display("FAIL wrap_load got tick/pend %b exp 11", {tick[0], div_pending[0]});
    end
    since = 0;
    for (int i = 0; i < 14; i++) begin
      clk_step();
      since++;
      n_cmp++;
      if ({low_clock, tick, div_pending} !== exp_vec()) begin
        n_err++; $display("FAIL wrap cyc %0d got %b exp %b", cyc, {low_clock, tick, div_pending}, exp_vec());
      end
      if (tick[0] === 1'b1) begin gaps.push_back(since); since = 0; end
    end
    n_cmp++;
    if (gaps.size() < 2 || gaps[0] != 4 || gaps[1] != 7) begin
      n_err++; $display("FAIL wrap_gaps got %p exp 4,7", gaps);
    end
  endtask

  task automatic test_disable();
    int steps;
    bit seen;
    for (int i = 0; i < 3; i++) clk_step();
    enable[0] = 1'b0;
    clk_step();
    n_cmp++;
    if ({low_clock[0], tick[0]} !== 2'b00) begin
      n_err++; $display("FAIL dis_low got %b exp 00", {low_clock[0], tick[0]});
    end
    div_ch = 0; div_value = 2; div_load = 1'b1;
    clk_step();
    div_load = 1'b0;
    n_cmp++;
    if (div_pending[0] !== 1'b1) begin n_err++; $display("FAIL dis_pend_set got %b exp 1", div_pending[0]); end
    clk_step();
    n_cmp++;
    if ({low_clock[0], div_pending[0]} !== 2'b00) begin
      n_err++; $display("FAIL dis_pend_clr got low/pend %b exp 00", {low_clock[0], div_pending[0]});
    end
    enable[0] = 1'b1;
    steps = 0; seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      clk_step();
      steps++;
      n_cmp++;
      if ({low_clock, tick, div_pending} !== exp_vec()) begin
        n_err++; $display("FAIL dis cyc %0d got %b exp %b", cyc, {low_clock, tick, div_pending}, exp_vec());
      end
      if (tick[0] === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen || steps != 2) begin n_err++; $display("FAIL dis_first_toggle got %0d exp 2", steps); end
  endtask

  task automatic test_bad_channel();
    div_ch = 3; div_value = 1; div_load = 1'b1;
    for (int i = 0; i < 8; i++) begin
      clk_step();
      div_load = 1'b0;
      n_cmp++;
      if ({low_clock, tick, div_pending} !== exp_vec()) begin
        n_err++; $display("FAIL bad_ch cyc %0d got %b exp %b", cyc, {low_clock, tick, div_pending}, exp_vec());
      end
      if (i == 0) begin
        n_cmp++;
        if (div_pending !== 2'b00) begin n_err++; $display("FAIL bad_ch_pend got %b exp 00", div_pending); end
      end
    end
  endtask

  task automatic test_async_reset();
    bit seen;
    div_load = 1'b1; div_ch = 0; div_value = 9;
    clk_step();
    div_ch = 1;
    clk_step();
    div_load = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      clk_step();
      n_cmp++;
      if ({low_clock, tick, div_pending} !== exp_vec()) begin
        n_err++; $display("FAIL arst_pre cyc %0d got %b exp %b", cyc, {low_clock, tick, div_pending}, exp_vec());
      end
      if (m_low[0] && m_rem[0] >= 3 && m_rem[1] >= 3) seen = 1'b1;
    end
    div_load = 1'b1; div_ch = 0; div_value = 5;
    clk_step();
    div_ch = 1; div_value = 4;
    clk_step();
    div_load = 1'b0;
    n_cmp++;
    if ({low_clock[0], div_pending} !== 3'b111) begin
      n_err++; $display("FAIL arst_setup got low0/pend %b exp 111", {low_clock[0], div_pending});
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({low_clock, tick, div_pending} !== '0) begin
      n_err++; $display("FAIL arst_immediate got %b exp %b", {low_clock, tick, div_pending}, {VW{1'b0}});
    end
    model_reset();
    #2 reset = 1'b1;
    test_default_period("arst_period");
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(7, 0) == 0) enable = N_CH'($urandom_range(3, 0));
      div_load  = ($urandom_range(3, 0) == 0);
      div_ch    = CH_W'($urandom_range(3, 0));
      div_value = CNT_W'($urandom_range(6, 0));
      clk_step();
      n_cmp++;
      if ({low_clock, tick, div_pending} !== exp_vec()) begin
        n_err++; $display("FAIL rand cyc %0d got %b exp %b", cyc, {low_clock, tick, div_pending}, exp_vec());
      end
    end
    div_load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_default_period("default");
    test_load_midperiod();
    test_load_zero();
    test_load_on_wrap();
    test_disable();
    test_bad_channel();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
